// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//
// Contents:
//   XLEN_DEF / PC_W_DEF  default instruction and PC widths
//   fetch_state_t        fetch FSM states (IDLE, RUN, HALT)
//   if_id_t              IF_ID payload {pc, instr} at the default widths
//   in_range()           word-index range check against a memory depth
package fetch_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned PC_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] instr;
    } if_id_t;

    // Widened to 64 bits so any PC width up to 64 compares without truncation.
    function automatic logic in_range(input logic [63:0] idx, input int unsigned depth);
        return idx < 64'(depth);
    endfunction

endpackage

// File: rtl/fetch_imem.sv
// Instruction memory for the fetch stage.
//
// Synchronous write port, combinational read port. Both ports ignore
// addresses at or beyond DEPTH, so DEPTH need not be a power of two.
// Contents are never cleared; the write port works regardless of reset.
//
// Ports:
//   clock  in   write clock, rising edge
//   we     in   write enable
//   waddr  in   write word address
//   wdata  in   write data
//   raddr  in   read word address (full PC width)
//   rdata  out  read data, zero when raddr is out of range
module fetch_imem
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned RAW   = PC_W_DEF
) (
    input  logic            clock,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RAW-1:0]  raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clock) begin
        if (we && in_range(64'(waddr), DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    // A same-cycle write lands on the edge, so a read this cycle sees old data.
    always_comb begin
        rdata = '0;
        if (in_range(64'(raddr), DEPTH)) begin
            rdata = mem[AW'(raddr)];
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with stall, branch redirect and halt-on-range.
//
// Holds the PC and a loadable instruction memory and drives the IF_ID
// register {pc, instr} to decode under a valid/ready handshake. After reset
// the stage spends one IDLE cycle, then fetches one word per cycle in RUN.
// A redirect flushes IF_ID (one bubble) and reloads the PC; fetching a PC
// beyond the memory stops the stage in HALT until a redirect or reset.
//
// Optional feature (define FETCH_PERF_EN): adds perf_fetched and
// perf_bubbles counters; without it those ports do not exist.
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   imem_we       in   program-load write enable
//   imem_waddr    in   program-load word address
//   imem_wdata    in   program-load data
//   id_ready      in   decode accepts IF_ID this cycle
//   redirect      in   taken branch/jump: flush and refetch
//   redirect_pc   in   redirect target word index
//   IF_ID         out  {pc, instr}; pc in the upper PC_W bits
//   IF_ID_valid   out  IF_ID holds a real instruction
//   perf_fetched  out  completed transfers (FETCH_PERF_EN only)
//   perf_bubbles  out  RUN cycles empty due to redirect (FETCH_PERF_EN only)
//   halted        out  fetch stopped
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN       = XLEN_DEF,
    parameter int unsigned     PC_W       = PC_W_DEF,
    parameter int unsigned     IMEM_DEPTH = 128,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [XLEN-1:0]               imem_wdata,
    input  logic                          id_ready,
    input  logic                          redirect,
    input  logic [PC_W-1:0]               redirect_pc,
    output logic [PC_W+XLEN-1:0]          IF_ID,
    output logic                          IF_ID_valid,
`ifdef FETCH_PERF_EN
    output logic [31:0]                   perf_fetched,
    output logic [31:0]                   perf_bubbles,
`endif
    output logic                          halted
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_w_t;

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q;
    if_id_w_t        if_id_q;
    logic            valid_q;
    logic [XLEN-1:0] rdata;

    logic stall;
    logic pc_ok;
    logic tgt_ok;
    logic take_redirect;
    logic do_fetch;
    logic do_drop;

    fetch_imem #(
        .XLEN  (XLEN),
        .DEPTH (IMEM_DEPTH),
        .AW    (AW),
        .RAW   (PC_W)
    ) u_imem (
        .clock (clock),
        .we    (imem_we),
        .waddr (imem_waddr),
        .wdata (imem_wdata),
        .raddr (pc_q),
        .rdata (rdata)
    );

    // An empty IF_ID never stalls: the next fetch overwrites it.
    assign stall         = valid_q && !id_ready;
    assign pc_ok         = in_range(64'(pc_q), IMEM_DEPTH);
    assign tgt_ok        = in_range(64'(redirect_pc), IMEM_DEPTH);
    assign take_redirect = redirect && (state_q != IDLE);

    // FSM: state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. Redirect outranks both stall and the range check.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if (redirect) begin
                    state_d = tgt_ok ? RUN : HALT;
                end else if (!stall && !pc_ok) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (redirect) begin
                    state_d = tgt_ok ? RUN : HALT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs and datapath controls
    always_comb begin
        do_fetch = 1'b0;
        do_drop  = 1'b0;
        if (state_q == RUN && !redirect && !stall) begin
            do_fetch = pc_ok;
            do_drop  = !pc_ok;
        end
        halted = (state_q == HALT);
    end

    // PC and IF_ID register. A redirect leaves the IF_ID payload alone and
    // only clears valid; the target is fetched on the following cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            if_id_q <= '0;
            valid_q <= 1'b0;
        end else if (take_redirect) begin
            pc_q    <= redirect_pc;
            valid_q <= 1'b0;
        end else if (do_fetch) begin
            if_id_q <= '{pc: pc_q, instr: rdata};
            valid_q <= 1'b1;
            pc_q    <= pc_q + PC_W'(1);
        end else if (do_drop) begin
            valid_q <= 1'b0;
        end
    end

    assign IF_ID       = if_id_q;
    assign IF_ID_valid = valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] bubbles_q;
    logic        redir_bub_q;  // the current empty IF_ID was caused by a redirect

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetched_q   <= '0;
            bubbles_q   <= '0;
            redir_bub_q <= 1'b0;
        end else begin
            redir_bub_q <= take_redirect && tgt_ok;
            if (state_q != HALT && valid_q && id_ready) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (state_q == RUN && !valid_q && redir_bub_q) begin
                bubbles_q <= bubbles_q + 32'd1;
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. Two instances share stimulus: one with
// a 128-word memory and one with a 4-word memory (to reach halt-on-range).
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_we = 1'b0;
    logic [6:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        id_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        we_b;
    logic [1:0]  waddr_b;
    logic [63:0] if_id_a, if_id_b;
    logic        valid_a, valid_b, halted_a, halted_b;
`ifdef FETCH_PERF_EN
    logic [31:0] pf_a, pb_a, pf_b, pb_b;
`endif

    assign we_b    = imem_we && (waddr < 7'd4);
    assign waddr_b = waddr[1:0];

    always #5 clock = ~clock;

    fetch_stage #(.IMEM_DEPTH(128)) dut_a (
        .clock       (clock),
        .reset       (reset),
        .imem_we     (imem_we),
        .imem_waddr  (waddr),
        .imem_wdata  (wdata),
        .id_ready    (id_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .IF_ID       (if_id_a),
        .IF_ID_valid (valid_a),
`ifdef FETCH_PERF_EN
        .perf_fetched(pf_a),
        .perf_bubbles(pb_a),
`endif
        .halted      (halted_a)
    );

    fetch_stage #(.IMEM_DEPTH(4)) dut_b (
        .clock       (clock),
        .reset       (reset),
        .imem_we     (we_b),
        .imem_waddr  (waddr_b),
        .imem_wdata  (wdata),
        .id_ready    (id_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .IF_ID       (if_id_b),
        .IF_ID_valid (valid_b),
`ifdef FETCH_PERF_EN
        .perf_fetched(pf_b),
        .perf_bubbles(pb_b),
`endif
        .halted      (halted_b)
    );

    // ---------------- reference model ----------------
    int unsigned depth [2] = '{128, 4};
    logic [31:0] prog  [5] = '{32'h0AAAAAAA, 32'h0BBBBBBB, 32'h0CCCCCCC,
                               32'h0DDDDDDD, 32'h0FFFFFFF};
    logic [31:0] m_mem [2][128];
    logic [31:0] m_pc  [2];
    logic [63:0] m_ifid[2];
    bit          m_valid[2];
    int          m_mode[2];   // 0: waiting after reset, 1: fetching, 2: stopped
    logic [31:0] m_pf[2], m_pb[2];
    bit          m_rb[2];

    int checks = 0;
    int failures = 0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pc[d] = 0; m_ifid[d] = 0; m_valid[d] = 0; m_mode[d] = 0;
            m_pf[d] = 0; m_pb[d] = 0; m_rb[d] = 0;
        end
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                m_pc[d] = 0; m_ifid[d] = 0; m_valid[d] = 0; m_mode[d] = 0;
                m_pf[d] = 0; m_pb[d] = 0; m_rb[d] = 0;
            end else begin
                bit stall;
                bit nrb;
                stall = m_valid[d] && !id_ready;
                nrb = 0;
                if (m_mode[d] != 2 && m_valid[d] && id_ready) m_pf[d]++;
                if (m_mode[d] == 1 && !m_valid[d] && m_rb[d]) m_pb[d]++;
                if (m_mode[d] == 0) begin
                    m_mode[d] = 1;
                end else if (redirect) begin
                    m_valid[d] = 0;
                    m_pc[d] = redirect_pc;
                    if (redirect_pc < depth[d]) begin
                        m_mode[d] = 1; nrb = 1;
                    end else begin
                        m_mode[d] = 2;
                    end
                end else if (m_mode[d] == 1 && !stall) begin
                    if (m_pc[d] >= depth[d]) begin
                        m_valid[d] = 0; m_mode[d] = 2;
                    end else begin
                        m_ifid[d] = {m_pc[d], m_mem[d][m_pc[d][6:0]]};
                        m_valid[d] = 1;
                        m_pc[d] = m_pc[d] + 1;
                    end
                end
                m_rb[d] = nrb;
            end
            if (imem_we && waddr < depth[d]) m_mem[d][waddr] = wdata;
        end
    endtask

    function automatic logic [65:0] expv(int d);
        return {m_mode[d] == 2, m_valid[d], m_ifid[d]};
    endfunction

    function automatic logic [65:0] got(int d);
        return (d == 0) ? {halted_a, valid_a, if_id_a} : {halted_b, valid_b, if_id_b};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #1 reset = 1'b0;
        model_reset();
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got(d) !== 66'd0) begin
                failures++;
                $display("FAIL reset_state dut%0d got=%h exp=0", d, got(d));
            end
        end
        // Program load while reset is held.
        for (int i = 0; i < 128; i++) begin
            imem_we = 1'b1;
            waddr = 7'(i);
            wdata = (i < 5) ? prog[i] : $urandom;
            tick();
        end
        imem_we = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got(d) !== expv(d)) begin
                failures++;
                $display("FAIL reset_hold dut%0d got=%h exp=%h", d, got(d), expv(d));
            end
        end
    endtask

    task automatic test_fetch();
        reset = 1'b1;
        id_ready = 1'b1;
        tick();
        checks++;
        if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
            failures++;
            $display("FAIL idle_cycle got=%b%b exp=00", valid_a, valid_b);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({valid_a, if_id_a} !== {1'b1, 32'(i), prog[i]}) begin
                failures++;
                $display("FAIL fetch_seq i=%0d got=%h exp=%h", i, {valid_a, if_id_a},
                         {1'b1, 32'(i), prog[i]});
            end
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (got(d) !== expv(d)) begin
                    failures++;
                    $display("FAIL fetch_model dut%0d got=%h exp=%h", d, got(d), expv(d));
                end
            end
        end
    endtask

    task automatic test_stall();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({valid_a, if_id_a} !== {1'b1, 32'd2, prog[2]}) begin
                failures++;
                $display("FAIL stall_hold c=%0d got=%h exp=%h", i, {valid_a, if_id_a},
                         {1'b1, 32'd2, prog[2]});
            end
        end
        id_ready = 1'b1;
        tick();
        checks++;
        if ({valid_a, if_id_a} !== {1'b1, 32'd3, prog[3]}) begin
            failures++;
            $display("FAIL stall_release got=%h exp=%h", {valid_a, if_id_a},
                     {1'b1, 32'd3, prog[3]});
        end
    endtask

    task automatic test_redirect();
        id_ready = 1'b0;
        tick();
        redirect = 1'b1;
        redirect_pc = 32'd1;
        tick();
        checks++;
        if (valid_a !== 1'b0 || if_id_a !== {32'd3, prog[3]}) begin
            failures++;
            $display("FAIL redirect_bubble got=%b/%h exp=0/%h", valid_a, if_id_a,
                     {32'd3, prog[3]});
        end
        redirect = 1'b0;
        id_ready = 1'b1;
        tick();
        checks++;
        if ({valid_a, if_id_a} !== {1'b1, 32'd1, prog[1]}) begin
            failures++;
            $display("FAIL redirect_target got=%h exp=%h", {valid_a, if_id_a},
                     {1'b1, 32'd1, prog[1]});
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (pb_a !== 32'd1 || pf_a !== m_pf[0]) begin
            failures++;
            $display("FAIL perf_after_redirect got=%0d/%0d exp=1/%0d", pb_a, pf_a, m_pf[0]);
        end
`endif
    endtask

    task automatic test_halt_range();
        id_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (got(d) !== expv(d)) begin
                    failures++;
                    $display("FAIL halt_run dut%0d got=%h exp=%h", d, got(d), expv(d));
                end
            end
        end
        checks++;
        if (halted_b !== 1'b1 || valid_b !== 1'b0 || if_id_b !== {32'd3, prog[3]}) begin
            failures++;
            $display("FAIL halt_range got=%b%b/%h exp=10/%h", halted_b, valid_b, if_id_b,
                     {32'd3, prog[3]});
        end
        redirect = 1'b1;
        redirect_pc = 32'd0;
        tick();
        redirect = 1'b0;
        checks++;
        if (halted_b !== 1'b0 || valid_b !== 1'b0) begin
            failures++;
            $display("FAIL halt_leave got=%b%b exp=00", halted_b, valid_b);
        end
        tick();
        checks++;
        if ({valid_b, if_id_b} !== {1'b1, 32'd0, prog[0]}) begin
            failures++;
            $display("FAIL halt_refetch got=%h exp=%h", {valid_b, if_id_b},
                     {1'b1, 32'd0, prog[0]});
        end
    endtask

    task automatic test_redirect_oob();
        redirect = 1'b1;
        redirect_pc = 32'd200;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (halted_a !== 1'b1 || valid_a !== 1'b0) begin
                failures++;
                $display("FAIL oob_halt c=%0d got=%b%b exp=10", i, halted_a, valid_a);
            end
            tick();
        end
        redirect = 1'b1;
        redirect_pc = 32'd4;
        tick();
        redirect = 1'b0;
        tick();
        checks++;
        if ({halted_a, valid_a, if_id_a} !== {2'b01, 32'd4, prog[4]}) begin
            failures++;
            $display("FAIL oob_recover got=%h exp=%h", {halted_a, valid_a, if_id_a},
                     {2'b01, 32'd4, prog[4]});
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got(d) !== expv(d)) begin
                failures++;
                $display("FAIL oob_model dut%0d got=%h exp=%h", d, got(d), expv(d));
            end
        end
    endtask

    // Write and fetch of the same word on one edge: the fetch sees old data.
    task automatic test_back_to_back();
        id_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'd1;
        tick();
        redirect = 1'b0;
        imem_we = 1'b1;
        waddr = 7'd1;
        wdata = 32'h12345678;
        tick();
        imem_we = 1'b0;
        checks++;
        if (if_id_a !== {32'd1, prog[1]} || if_id_b !== {32'd1, prog[1]}) begin
            failures++;
            $display("FAIL write_collision got=%h/%h exp=%h", if_id_a, if_id_b,
                     {32'd1, prog[1]});
        end
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        tick();
        checks++;
        if (if_id_a !== {32'd1, 32'h12345678}) begin
            failures++;
            $display("FAIL write_visible got=%h exp=%h", if_id_a, {32'd1, 32'h12345678});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 15) == 0);
            redirect_pc = ($urandom_range(0, 7) == 0) ? 32'd200 : 32'($urandom_range(0, 9));
            imem_we = ($urandom_range(0, 3) == 0);
            waddr = 7'($urandom_range(1, 127));
            wdata = $urandom;
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (got(d) !== expv(d)) begin
                    failures++;
                    $display("FAIL random c=%0d dut%0d got=%h exp=%h", i, d, got(d), expv(d));
                end
            end
`ifdef FETCH_PERF_EN
            checks++;
            if ({pf_a, pb_a, pf_b, pb_b} !== {m_pf[0], m_pb[0], m_pf[1], m_pb[1]}) begin
                failures++;
                $display("FAIL random_perf c=%0d got=%h exp=%h", i, {pf_a, pb_a, pf_b, pb_b},
                         {m_pf[0], m_pb[0], m_pf[1], m_pb[1]});
            end
`endif
        end
        imem_we = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic test_reset_mid();
        redirect = 1'b1;
        redirect_pc = 32'd2;
        tick();
        redirect = 1'b0;
        id_ready = 1'b1;
        tick();
        // Stalled with a redirect pending, then reset lands mid-cycle.
        id_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'd3;
        #2 reset = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got(d) !== 66'd0) begin
                failures++;
                $display("FAIL reset_async dut%0d got=%h exp=0", d, got(d));
            end
        end
        redirect = 1'b0;
        tick();
        reset = 1'b1;
        id_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({valid_a, if_id_a} !== {1'b1, 32'd0, prog[0]}) begin
            failures++;
            $display("FAIL reset_mem_kept got=%h exp=%h", {valid_a, if_id_a},
                     {1'b1, 32'd0, prog[0]});
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_halt_range();
        test_redirect_oob();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
